// File: rtl/ws2812_pkg.sv
// Shared WS2812B definitions: decoder state encoding and the NRZ timing
// constants (in 40 MHz clk cycles) used by both the generator and the decoder.
package ws2812_pkg;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW,
        ERR
    } dec_state_t;

    localparam int T0H      = 17;
    localparam int T1H      = 33;
    localparam int T0L      = 35;
    localparam int T1L      = 19;
    localparam int T_LATCH  = 2000;
    localparam int PIX_BITS = 24;

endpackage

// File: rtl/ws2812_sync.sv
// Multi-flop synchronizer for the asynchronous WS2812B input, plus single-cycle
// rising/falling edge pulses derived from the synchronized level.
module ws2812_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic ds,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Both edges see the same pipeline delay, so measured widths are exact.
    assign ds   = sync_reg[SYNC_STAGES-1];
    assign rise = ds & ~prev_reg;
    assign fall = ~ds & prev_reg;

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812B NRZ receiver: measures high pulses, classifies bits, packs 24-bit
// pixels (first bit in pixel[0]) and reports frame latches and width errors.
module ws2812_decoder
    import ws2812_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 6,
    parameter int BIT_THRESH  = 24,
    parameter int MAX_HIGH    = 48,
    parameter int RESET_LOW   = 1600,
    parameter int PIX_W       = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [23:0]      pixel,
    output logic             pixel_valid,
    output logic [PIX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic [PIX_W-1:0] frame_pixels,
    output logic             bit_error
);

    localparam int               WC_W     = $clog2(RESET_LOW + 1);
    localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(RESET_LOW);
    localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);
    localparam logic [WC_W-1:0]  MIN_W    = WC_W'(MIN_HIGH);
    localparam logic [WC_W-1:0]  THRESH_W = WC_W'(BIT_THRESH);
    localparam logic [WC_W-1:0]  MAX_W    = WC_W'(MAX_HIGH);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    logic ds, rise, fall;

    ws2812_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .ds    (ds),
        .rise  (rise),
        .fall  (fall)
    );

    dec_state_t       state_reg, state_next;
    logic [WC_W-1:0]  wc_reg, wc_next;
    logic [23:0]      sr_reg, sr_next;
    logic [4:0]       bit_cnt_reg, bit_cnt_next;
    logic [PIX_W-1:0] pix_cnt_reg, pix_cnt_next;
    logic [23:0]      pixel_reg, pixel_next;
    logic             pixel_valid_reg, pixel_valid_next;
    logic [PIX_W-1:0] pixel_index_reg, pixel_index_next;
    logic             frame_done_reg, frame_done_next;
    logic [PIX_W-1:0] frame_pixels_reg, frame_pixels_next;
    logic             bit_error_reg, bit_error_next;

    logic [WC_W-1:0]  wc_inc;
    logic             latch_hit;
    logic             bit_val;
    logic [23:0]      word;

    assign wc_inc    = (wc_reg == WC_MAX) ? wc_reg : wc_reg + WC_ONE;
    assign latch_hit = (wc_inc == WC_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= SYNC;
            wc_reg           <= '0;
            sr_reg           <= '0;
            bit_cnt_reg      <= '0;
            pix_cnt_reg      <= '0;
            pixel_reg        <= '0;
            pixel_valid_reg  <= 1'b0;
            pixel_index_reg  <= '0;
            frame_done_reg   <= 1'b0;
            frame_pixels_reg <= '0;
            bit_error_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wc_reg           <= wc_next;
            sr_reg           <= sr_next;
            bit_cnt_reg      <= bit_cnt_next;
            pix_cnt_reg      <= pix_cnt_next;
            pixel_reg        <= pixel_next;
            pixel_valid_reg  <= pixel_valid_next;
            pixel_index_reg  <= pixel_index_next;
            frame_done_reg   <= frame_done_next;
            frame_pixels_reg <= frame_pixels_next;
            bit_error_reg    <= bit_error_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        wc_next           = wc_reg;
        sr_next           = sr_reg;
        bit_cnt_next      = bit_cnt_reg;
        pix_cnt_next      = pix_cnt_reg;
        pixel_next        = pixel_reg;
        pixel_valid_next  = 1'b0;
        pixel_index_next  = pixel_index_reg;
        frame_done_next   = 1'b0;
        frame_pixels_next = frame_pixels_reg;
        bit_error_next    = 1'b0;
        bit_val           = (wc_reg > THRESH_W);
        word              = {bit_val, sr_reg[23:1]};

        case (state_reg)
            SYNC: begin
                if (ds) begin
                    wc_next = '0;
                end else if (latch_hit) begin
                    state_next       = IDLE;
                    wc_next          = '0;
                    pix_cnt_next     = '0;
                    pixel_index_next = '0;
                end else begin
                    wc_next = wc_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                    wc_next    = WC_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (wc_reg < MIN_W || wc_reg > MAX_W) begin
                        state_next = ERR;
                    end else begin
                        state_next = LOW;
                        wc_next    = WC_ONE;
                        if (bit_cnt_reg == 5'd23) begin
                            pixel_next       = word;
                            pixel_valid_next = 1'b1;
                            pixel_index_next = pix_cnt_reg;
                            pix_cnt_next     = (pix_cnt_reg == PIX_MAX) ? pix_cnt_reg
                                                                        : pix_cnt_reg + 1'b1;
                            bit_cnt_next     = '0;
                            sr_next          = '0;
                        end else begin
                            sr_next      = word;
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end
                end else begin
                    // A stuck-high line is flagged without waiting for its falling edge.
                    wc_next = wc_inc;
                    if (wc_inc > MAX_W) begin
                        state_next = ERR;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_next = HIGH;
                    wc_next    = WC_ONE;
                end else if (latch_hit) begin
                    bit_error_next = (bit_cnt_reg != '0);
                    if (bit_cnt_reg != '0 || pix_cnt_reg != '0) begin
                        frame_done_next   = 1'b1;
                        frame_pixels_next = pix_cnt_reg;
                    end
                    state_next       = IDLE;
                    wc_next          = '0;
                    sr_next          = '0;
                    bit_cnt_next     = '0;
                    pix_cnt_next     = '0;
                    pixel_index_next = '0;
                end else begin
                    wc_next = wc_inc;
                end
            end
            ERR: begin
                bit_error_next = 1'b1;
                state_next     = SYNC;
                wc_next        = '0;
                sr_next        = '0;
                bit_cnt_next   = '0;
            end
            default: begin
                state_next = SYNC;
                wc_next    = '0;
            end
        endcase
    end

    assign pixel        = pixel_reg;
    assign pixel_valid  = pixel_valid_reg;
    assign pixel_index  = pixel_index_reg;
    assign frame_done   = frame_done_reg;
    assign frame_pixels = frame_pixels_reg;
    assign bit_error    = bit_error_reg;

endmodule
